// File: rtl/touch_pkg.sv
// touch_pkg: shared types and defaults for the touch-hold tracker.
//   area_t      - quadrant code reported on Area_Code / Hold_Area
//   state_t     - press-tracking state
//   SPLIT_*     - default quadrant split thresholds
//   quadrant()  - maps a coordinate pair onto a quadrant
package touch_pkg;

  typedef enum logic [1:0] {
    AREA_LT = 2'd0,
    AREA_RT = 2'd1,
    AREA_LB = 2'd2,
    AREA_RB = 2'd3
  } area_t;

  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    WAIT_COORD    = 2'd1,
    HOLDING       = 2'd2,
    RELEASE_GUARD = 2'd3
  } state_t;

  localparam logic [11:0] SPLIT_X_DEFAULT = 12'd2048;
  localparam logic [11:0] SPLIT_Y_DEFAULT = 12'd2048;

  // Bit 0 selects the right half, bit 1 the bottom half.
  function automatic area_t quadrant(input logic [11:0] x, input logic [11:0] y,
                                     input logic [11:0] sx, input logic [11:0] sy);
    return area_t'({(y >= sy), (x >= sx)});
  endfunction

endpackage

// File: rtl/bcd4_sat_counter.sv
// bcd4_sat_counter: four-digit BCD up-counter that sticks at 9999.
//   Clock - clock
//   Reset - asynchronous active-high reset, count -> 0000
//   clear - synchronous clear, wins over inc
//   inc   - add one (ignored once the count is 9999)
//   bcd   - registered count {d3,d2,d1,d0}
module bcd4_sat_counter (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] bcd
);

  logic [15:0] bcd_next;
  logic [3:0]  carry;
  logic        at_max;

  assign at_max = (bcd == 16'h9999);

  // carry[gi] means digit gi must step; it ripples while lower digits are 9.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] d;
      assign d = bcd[gi*4 +: 4];
      if (gi == 0) begin : g_first
        assign carry[gi] = inc && !at_max;
      end else begin : g_rest
        assign carry[gi] = carry[gi-1] && (bcd[gi*4-4 +: 4] == 4'd9);
      end
      assign bcd_next[gi*4 +: 4] = carry[gi] ? ((d == 4'd9) ? 4'd0 : d + 4'd1) : d;
    end
  endgenerate

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bcd <= 16'h0000;
    end else if (clear) begin
      bcd <= 16'h0000;
    end else begin
      bcd <= bcd_next;
    end
  end

endmodule

// File: rtl/touch_hold_tracker.sv
// touch_hold_tracker: turns raw touch status/coordinates into a quadrant code,
// a debounced press flag, per-hold-period pulses and a BCD press duration.
//   Clock        - system clock
//   Reset        - asynchronous active-high reset
//   Touch_En     - pen-down status
//   Coord_En     - one-cycle strobe qualifying X_Coord/Y_Coord
//   X_Coord      - touch X
//   Y_Coord      - touch Y
//   Touch_Active - debounced press flag (HOLDING or RELEASE_GUARD)
//   Area_Code    - last captured quadrant
//   Area_Valid   - Area_Code was captured during the current press
//   Hold_Pulse   - one-cycle pulse per HOLD_MS spent in one quadrant
//   Hold_Area    - quadrant credited by Hold_Pulse (zero otherwise)
//   Press_BCD    - press duration in ms, BCD, saturating at 9999
module touch_hold_tracker
  import touch_pkg::*;
#(
  parameter int          CLK_PER_MS = 50000,
  parameter int          HOLD_MS    = 1000,
  parameter int          RELEASE_MS = 20,
  parameter logic [11:0] SPLIT_X    = SPLIT_X_DEFAULT,
  parameter logic [11:0] SPLIT_Y    = SPLIT_Y_DEFAULT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Touch_En,
  input  logic        Coord_En,
  input  logic [11:0] X_Coord,
  input  logic [11:0] Y_Coord,
  output logic        Touch_Active,
  output logic [1:0]  Area_Code,
  output logic        Area_Valid,
  output logic        Hold_Pulse,
  output logic [1:0]  Hold_Area,
  output logic [15:0] Press_BCD
);

  // Widths never drop below one bit so degenerate parameters stay legal.
  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int HW = (HOLD_MS    > 1) ? $clog2(HOLD_MS)    : 1;
  localparam int GW = (RELEASE_MS > 1) ? $clog2(RELEASE_MS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MS - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(RELEASE_MS - 1);

  state_t        state;
  logic [PW-1:0] presc;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] guard_cnt;
  logic          ms_tick;
  logic          pressed;
  area_t         coord_area;
  logic          bcd_clear;
  logic          bcd_inc;

  assign pressed    = (state == HOLDING) || (state == RELEASE_GUARD);
  assign ms_tick    = pressed && (presc == PRESC_LAST);
  assign coord_area = quadrant(X_Coord, Y_Coord, SPLIT_X, SPLIT_Y);

  // A new press starts its duration from zero; only HOLDING accumulates.
  assign bcd_clear  = (state == IDLE) && Touch_En;
  assign bcd_inc    = (state == HOLDING) && ms_tick;

  // Millisecond prescaler: parked at zero until the press is confirmed, so
  // the first ms of a press is a full CLK_PER_MS cycles long. It keeps
  // running through RELEASE_GUARD so guard time is measured in real ms.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      presc <= '0;
    end else if (!pressed || ms_tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      Touch_Active <= 1'b0;
      Area_Code    <= 2'b00;
      Area_Valid   <= 1'b0;
      Hold_Pulse   <= 1'b0;
      Hold_Area    <= 2'b00;
      hold_cnt     <= '0;
      guard_cnt    <= '0;
    end else begin
      Hold_Pulse <= 1'b0;
      Hold_Area  <= 2'b00;
      case (state)
        IDLE: begin
          if (Touch_En) begin
            state <= WAIT_COORD;
          end
        end

        WAIT_COORD: begin
          // A pen lift beats a simultaneous strobe: the press never started.
          if (!Touch_En) begin
            state <= IDLE;
          end else if (Coord_En) begin
            Area_Code    <= coord_area;
            Area_Valid   <= 1'b1;
            Touch_Active <= 1'b1;
            hold_cnt     <= '0;
            state        <= HOLDING;
          end
        end

        HOLDING: begin
          // Moving to another quadrant restarts the period and suppresses
          // any pulse that the same cycle's tick would have produced.
          if (Coord_En && (coord_area != area_t'(Area_Code))) begin
            Area_Code <= coord_area;
            hold_cnt  <= '0;
          end else if (ms_tick) begin
            if (hold_cnt == HOLD_LAST) begin
              Hold_Pulse <= 1'b1;
              Hold_Area  <= Area_Code;
              hold_cnt   <= '0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          if (!Touch_En) begin
            guard_cnt <= '0;
            state     <= RELEASE_GUARD;
          end
        end

        RELEASE_GUARD: begin
          // Hold counter and duration are frozen here; only the guard runs.
          if (Touch_En) begin
            state <= HOLDING;
          end else if (ms_tick) begin
            if (guard_cnt == GUARD_LAST) begin
              Area_Valid   <= 1'b0;
              Touch_Active <= 1'b0;
              state        <= IDLE;
            end else begin
              guard_cnt <= guard_cnt + GW'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  bcd4_sat_counter u_press_bcd (
    .Clock (Clock),
    .Reset (Reset),
    .clear (bcd_clear),
    .inc   (bcd_inc),
    .bcd   (Press_BCD)
  );

endmodule

// File: doc/touch_hold_tracker.md
Name: touch_hold_tracker

Overview:
Sits between Touch_Panel_Controller and the quadrant colour-counter / seven-segment logic in the touch-panel top level. It converts raw touch status and 12-bit coordinates into four outputs: a registered quadrant code, a debounced touch-active flag, a one-cycle pulse for each full hold period spent in one quadrant, and a 4-digit BCD press-duration count in milliseconds. Consumers use Hold_Pulse to step their colour counters and Press_BCD to drive the displays, with no free-running counters of their own.

Parameters:
CLK_PER_MS, 50000, Clock cycles per 1 ms tick (50 MHz clock).
HOLD_MS, 1000, continuous ms in one quadrant per Hold_Pulse.
RELEASE_MS, 20, ms Touch_En may drop before the press counts as ended.
SPLIT_X, 12'd2048, X threshold; X >= SPLIT_X is the right half.
SPLIT_Y, 12'd2048, Y threshold; Y >= SPLIT_Y is the bottom half.

Ports:
Clock  input  1  system clock, 50 MHz.
Reset  input  1  asynchronous, active-high reset.
Touch_En  input  1  pen-down status from Touch_Panel_Controller.
Coord_En  input  1  one-cycle strobe; X_Coord/Y_Coord valid this cycle.
X_Coord  input  12  touch X coordinate.
Y_Coord  input  12  touch Y coordinate.
Touch_Active  output  1  debounced press flag.
Area_Code  output  2  quadrant: 0 X<SX,Y<SY; 1 X>=SX,Y<SY; 2 X<SX,Y>=SY; 3 X>=SX,Y>=SY.
Area_Valid  output  1  Area_Code holds a quadrant captured during the current press.
Hold_Pulse  output  1  one-cycle pulse per completed hold period.
Hold_Area  output  2  quadrant credited by Hold_Pulse; valid only while Hold_Pulse=1.
Press_BCD  output  16  four BCD digits {d3,d2,d1,d0} of press duration in ms, saturating at 9999.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all outputs 0; prescaler, hold and guard counters 0.
- Prescaler counts 0..CLK_PER_MS-1. While in IDLE or WAIT_COORD it is held at 0. Its terminal count is ms_tick.
- State IDLE:
  - Touch_En=1 moves to WAIT_COORD, clears Press_BCD and sets prescaler to 0.
  - Press_BCD otherwise holds the last press duration.
- State WAIT_COORD:
  - Coord_En=1 latches the quadrant into Area_Code, sets Area_Valid=1 and the hold counter to 0, then moves to HOLDING. Area_Code and Area_Valid update the cycle after the strobe.
  - Touch_En=0 returns to IDLE.
  - Touch_Active=0 in this state.
- State HOLDING (Touch_Active=1):
  - On each ms_tick, Press_BCD increments with decimal carry. At 9999 it stays at 9999.
  - On each ms_tick, the hold counter increments. When it reaches HOLD_MS-1 on a tick, Hold_Pulse=1 and Hold_Area=Area_Code for that cycle, and the hold counter wraps to 0.
  - Coord_En with a different quadrant: Area_Code updates, the hold counter is cleared and no Hold_Pulse is issued that cycle, even if a tick completes a period. Press_BCD keeps counting.
  - Coord_En with the same quadrant has no effect.
  - Touch_En=0 moves to RELEASE_GUARD and clears the guard counter. A ms_tick in that same cycle is still counted.
- State RELEASE_GUARD (Touch_Active=1):
  - Press_BCD and the hold counter are frozen. The prescaler keeps running and the guard counter counts ms_ticks.
  - Touch_En=1 before the guard counter reaches RELEASE_MS returns to HOLDING with no counters cleared.
  - Guard counter reaching RELEASE_MS on a tick moves to IDLE and clears Area_Valid and Touch_Active. Area_Code and Press_BCD hold.
  - Coord_En in this state is ignored.
- Hold_Pulse never occurs outside HOLDING and is never asserted on two consecutive cycles.
- Counter widths are $clog2 of the relevant parameter. All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Package touch_pkg:
  - typedef enum logic [1:0] area_t with AREA_LT=0, AREA_RT=1, AREA_LB=2, AREA_RB=3.
  - typedef enum for the states IDLE, WAIT_COORD, HOLDING, RELEASE_GUARD.
  - Defaults for the SPLIT_X and SPLIT_Y constants.
- Sub-module bcd4_sat_counter:
  - Inputs Clock, Reset, clear, inc; output 16-bit BCD.
  - Saturates at 9999.
  - Verified standalone.

Test Plan:
All runs use CLK_PER_MS=4, HOLD_MS=3, RELEASE_MS=2.
1. Touch_En=1, Coord_En with X=100,Y=100, hold 40 cycles -> Area_Code=0 and Area_Valid=1 one cycle after the strobe; Hold_Pulse at ms 3, 6 and 9 with Hold_Area=0; Press_BCD=0x0010 when sampled at the end of the 40 cycles.
2. Hold in quadrant 0 for 2 ms, then Coord_En X=3000,Y=100 -> Area_Code=1, hold counter restarts; first Hold_Pulse (Hold_Area=1) 3 ms after the switch; Press_BCD continues from 0x0002.
3. Drop Touch_En for 1 ms mid-hold, then reassert -> Touch_Active stays 1; Press_BCD and the hold counter resume from their frozen values; no IDLE entry.
4. Drop Touch_En for 3 ms -> IDLE after 2 ms; Touch_Active=0 and Area_Valid=0; Press_BCD retains its value; the next press clears it to 0.
5. Force Press_BCD to 0x9998 and hold for 5 ms -> reads 0x9999 and stays there; Hold_Pulse continues.
6. Assert Reset asynchronously mid-HOLDING while Hold_Pulse=1 -> all outputs 0 immediately (before the next Clock edge); after release, state=IDLE.
